// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } ctrl_state_t;

  // Opcodes of the supported RV32I subset
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUControl codes consumed by arithmetic_logic_unit
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Internal ALUOp classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
    logic [1:0] imm;
    case (opcode)
      OP_LW:   imm = IMM_I;
      OP_I:    imm = IMM_I;
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALUControl.
// Subtraction for funct3=000 is chosen only for R-type (op[5]=1) with funct7b5=1,
// so addi with a set instr[30] bit still adds.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Select the ALU operation from the ALUOp class and funct fields
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Moore outputs decode from the registered state; ImmSrc follows op and PCWrite
// combines the PC-update and branch-taken conditions with the live ALU zero flag.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes lock into S_TRAP
// and raise illegal_instr instead of being treated as a NOP).
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic [2:0] ALUControl,
  output logic       illegal_instr
`else
  output logic [2:0] ALUControl
`endif
);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic [1:0]  alu_op;
  logic        branch;
  logic        pc_update;

  // State register; reset aborts any instruction asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing, including the opcode dispatch in DECODE
  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW:   next_state = S_MEMADR;
          OP_SW:   next_state = S_MEMADR;
          OP_R:    next_state = S_EXECR;
          OP_I:    next_state = S_EXECI;
          OP_BEQ:  next_state = S_BEQ;
          OP_JAL:  next_state = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: next_state = S_TRAP;
`else
          default: next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (op[5]) begin
          next_state = S_MEMWR;
        end else begin
          next_state = S_MEMRD;
        end
      end
      S_MEMRD:  next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = S_FETCH;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BEQ:    next_state = S_FETCH;
      S_JAL:    next_state = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   next_state = S_TRAP;
`endif
      default:  next_state = S_RESET;
    endcase
  end

  // Per-state datapath controls; everything idles to zero unless the state drives it
  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    RegWrite  = 1'b0;
    alu_op    = ALUOP_ADD;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // PC enable: unconditional update or taken branch using this cycle's zero flag
  always_comb begin
    PCWrite = pc_update | (branch & zero);
  end

  // Immediate format from the opcode, held at I-format while in reset
  always_comb begin
    if (state == S_RESET) begin
      ImmSrc = IMM_I;
    end else begin
      ImmSrc = imm_src_for(op);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Trap indication is a pure decode of the locked trap state
  always_comb begin
    illegal_instr = (state == S_TRAP);
  end
`endif

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule
